// File: rtl/rle_job_scheduler_pkg.sv
// Shared types for the RLE job scheduler: FSM states and the packed job word.
package rle_job_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StWait   = 2'd2,
    StReport = 2'd3
  } sched_state_e;

  localparam int unsigned JobW = 96;

  // msg_addr occupies bits [31:0], msg_size [63:32], rle_addr [95:64].
  typedef struct packed {
    logic [31:0] rle_addr;
    logic [31:0] msg_size;
    logic [31:0] msg_addr;
  } job_t;

endpackage

// File: rtl/rle_job_scheduler_fifo.sv
// Synchronous job FIFO with wrap-around pointers carrying an extra lap bit.
module rle_job_scheduler_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    full  = (count == FullCnt);
    empty = (count == '0);
    rdata = mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/rle_job_scheduler.sv
// Sequences queued RLE jobs into the core one at a time, measuring latency and enforcing a watchdog.
module rle_job_scheduler
  import rle_job_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [31:0]              job_msg_addr,
  input  logic [31:0]              job_msg_size,
  input  logic [31:0]              job_rle_addr,
  output logic                     rle_start,
  output logic [31:0]              rle_message_addr,
  output logic [31:0]              rle_message_size,
  output logic [31:0]              rle_addr,
  input  logic                     rle_done,
  input  logic [31:0]              rle_size,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_rle_size,
  output logic [CNT_W-1:0]         res_cycles,
  output logic                     res_error,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [CNT_W-1:0]         total_cycles
);

  localparam int unsigned SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  sched_state_e     state_q, state_d;
  job_t             job_q, head;
  logic             fifo_full, fifo_empty, push, pop;
  logic [SW-1:0]    start_cnt_q;
  logic [WW-1:0]    wd_q;
  logic [CNT_W-1:0] lat_q, lat_inc, total_q;
  logic [31:0]      res_rle_size_q;
  logic [CNT_W-1:0] res_cycles_q;
  logic             res_error_q;
  logic             timed_out, zero_job;
  logic [CNT_W:0]   total_sum;

  assign push = job_valid & ~fifo_full;

  rle_job_scheduler_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JobW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({job_rle_addr, job_msg_size, job_msg_addr}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count)
  );

  always_comb begin
    zero_job  = (head.msg_size == '0);
    timed_out = (wd_q == WW'(TIMEOUT - 1)) & ~rle_done;
    lat_inc   = (lat_q == '1) ? lat_q : lat_q + 1'b1;
    total_sum = {1'b0, total_q} + {1'b0, res_cycles_q};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!fifo_empty) state_d = zero_job ? StReport : StIssue;
      StIssue:  if (start_cnt_q == SW'(START_CYC - 1)) state_d = StWait;
      StWait:   if (rle_done || timed_out) state_d = StReport;
      StReport: if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    pop       = (state_q == StIdle) & ~fifo_empty;
    rle_start = (state_q == StIssue);
    res_valid = (state_q == StReport);
    busy      = (state_q != StIdle) | ~fifo_empty;
    job_ready = ~fifo_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_q          <= '0;
      start_cnt_q    <= '0;
      wd_q           <= '0;
      lat_q          <= '0;
      res_rle_size_q <= '0;
      res_cycles_q   <= '0;
      res_error_q    <= 1'b0;
      total_q        <= '0;
    end else begin
      if (pop) begin
        job_q       <= head;
        start_cnt_q <= '0;
        lat_q       <= CNT_W'(1);
        if (zero_job) begin
          res_rle_size_q <= '0;
          res_cycles_q   <= '0;
          res_error_q    <= 1'b0;
        end
      end
      if (state_q == StIssue) begin
        start_cnt_q <= start_cnt_q + 1'b1;
        lat_q       <= lat_inc;
        wd_q        <= '0;
      end
      if (state_q == StWait) begin
        lat_q <= lat_inc;
        wd_q  <= wd_q + 1'b1;
        // lat_q already counts the current cycle, so capture it directly.
        if (rle_done) begin
          res_rle_size_q <= rle_size;
          res_cycles_q   <= lat_q;
          res_error_q    <= 1'b0;
        end else if (timed_out) begin
          res_rle_size_q <= '0;
          res_cycles_q   <= lat_q;
          res_error_q    <= 1'b1;
        end
      end
      if (state_q == StReport && res_ready) begin
        total_q <= total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
      end
    end
  end

  assign rle_message_addr = job_q.msg_addr;
  assign rle_message_size = job_q.msg_size;
  assign rle_addr         = job_q.rle_addr;
  assign res_rle_size     = res_rle_size_q;
  assign res_cycles       = res_cycles_q;
  assign res_error        = res_error_q;
  assign total_cycles     = total_q;

endmodule

// File: tb/tb_rle_job_scheduler.sv
// Directed bench for rle_job_scheduler with a simple core model answering done after a set delay.
module tb_rle_job_scheduler;

  localparam int unsigned TIMEOUT = 4096;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned NEVER   = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic             job_valid;
  logic             job_ready;
  logic [31:0]      job_msg_addr, job_msg_size, job_rle_addr;
  logic             rle_start;
  logic [31:0]      rle_message_addr, rle_message_size, rle_addr;
  logic             rle_done = 1'b0;
  logic [31:0]      rle_size = '0;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_rle_size;
  logic [CNT_W-1:0] res_cycles;
  logic             res_error;
  logic             busy;
  logic [2:0]       queue_count;
  logic [CNT_W-1:0] total_cycles;

  int checks = 0;
  int errors = 0;

  rle_job_scheduler #(
    .DEPTH     (4),
    .START_CYC (2),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_msg_addr     (job_msg_addr),
    .job_msg_size     (job_msg_size),
    .job_rle_addr     (job_rle_addr),
    .rle_start        (rle_start),
    .rle_message_addr (rle_message_addr),
    .rle_message_size (rle_message_size),
    .rle_addr         (rle_addr),
    .rle_done         (rle_done),
    .rle_size         (rle_size),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_rle_size     (res_rle_size),
    .res_cycles       (res_cycles),
    .res_error        (res_error),
    .busy             (busy),
    .queue_count      (queue_count),
    .total_cycles     (total_cycles)
  );

  always #5 clk = ~clk;

  // Core model: done rises core_delay cycles after start falls, size = msg_size / 4.
  int unsigned core_delay = 30;
  int unsigned since      = 0;
  int unsigned start_hi   = 0;
  bit          armed      = 1'b0;

  always @(negedge clk) begin
    if (rle_start) begin
      armed    <= 1'b1;
      since    <= 0;
      rle_done <= 1'b0;
      start_hi <= start_hi + 1;
    end else if (armed) begin
      since <= since + 1;
      if (since + 1 > core_delay) begin
        rle_done <= 1'b1;
        rle_size <= rle_message_size >> 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r);
    job_valid    = 1'b1;
    job_msg_addr = a;
    job_msg_size = s;
    job_rle_addr = r;
    for (int n = 0; n < 50; n++) begin
      if (job_ready) break;
      step();
    end
    check("push_ready", job_ready, 1'b1);
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input int bound, input string tag);
    for (int n = 0; n < bound; n++) begin
      if (res_valid) break;
      step();
    end
    check(tag, res_valid, 1'b1);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    int unsigned s0;
    int          bad;
    logic [2:0]  exp_cnt [6];

    exp_cnt = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    reset        = 1'b1;
    job_valid    = 1'b0;
    job_msg_addr = '0;
    job_msg_size = '0;
    job_rle_addr = '0;
    res_ready    = 1'b0;
    step();
    step();
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_rle_start", rle_start, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_qcount", queue_count, 3'd0);
    check("rst_total", total_cycles, 32'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();

    // Single job
    s0 = start_hi;
    push(32'h0, 32'd48, 32'hC8);
    wait_res(200, "t1_res_valid");
    check("t1_rle_size", res_rle_size, 32'd12);
    check("t1_cycles", res_cycles, 32'd33);
    check("t1_error", res_error, 1'b0);
    check("t1_start_cycles", start_hi - s0, 32'd2);
    ack();
    check("t1_total", total_cycles, 32'd33);

    // Back-to-back stream while the core is busy
    push(32'h100, 32'd40, 32'h1000);
    repeat (4) step();
    for (int k = 1; k <= 4; k++) push(32'h100 + k, 32'd40 * (k + 1), 32'h1000 + k);
    job_valid    = 1'b1;
    job_msg_addr = 32'h105;
    job_msg_size = 32'd240;
    job_rle_addr = 32'h1005;
    step();
    check("t2_full_ready", job_ready, 1'b0);
    check("t2_full_count", queue_count, 3'd4);
    check("t2_busy", busy, 1'b1);
    for (int k = 0; k < 6; k++) begin
      wait_res(200, "t2_res_valid");
      check("t2_rle_size", res_rle_size, 32'd10 * (k + 1));
      check("t2_cycles", res_cycles, 32'd33);
      check("t2_qcount", queue_count, exp_cnt[k]);
      ack();
      if (k == 0) begin
        for (int n = 0; n < 10; n++) begin
          if (job_ready) break;
          step();
        end
        check("t2_fifth_ready", job_ready, 1'b1);
        step();
        job_valid = 1'b0;
        check("t2_fifth_count", queue_count, 3'd4);
      end
    end
    check("t2_total", total_cycles, 32'd231);

    // Zero-size job followed by a normal one
    s0 = start_hi;
    push(32'h30, 32'd0, 32'h12C);
    push(32'h40, 32'd40, 32'h200);
    wait_res(20, "t3_res_valid");
    check("t3_rle_size", res_rle_size, 32'd0);
    check("t3_cycles", res_cycles, 32'd0);
    check("t3_error", res_error, 1'b0);
    check("t3_no_start", start_hi - s0, 32'd0);
    check("t3_qcount", queue_count, 3'd1);
    ack();
    step();
    check("t3_next_start", rle_start, 1'b1);
    check("t3_next_addr", rle_message_addr, 32'h40);
    check("t3_next_size", rle_message_size, 32'd40);
    check("t3_next_rle_addr", rle_addr, 32'h200);

    // Hold the result for 20 cycles with another job queued
    wait_res(200, "t4_res_valid");
    push(32'h50, 32'd64, 32'h300);
    s0  = start_hi;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      if (!res_valid || res_rle_size != 32'd10 || res_cycles != 32'd33 || res_error ||
          rle_start || queue_count != 3'd1) bad++;
      step();
    end
    check("t4_hold_stable", bad, 0);
    check("t4_hold_no_start", start_hi - s0, 32'd0);
    core_delay = NEVER;
    ack();
    check("t4_total", total_cycles, 32'd264);

    // Watchdog: the core never answers
    wait_res(TIMEOUT + 100, "t5_res_valid");
    check("t5_error", res_error, 1'b1);
    check("t5_rle_size", res_rle_size, 32'd0);
    core_delay = 30;
    ack();

    // Next job proceeds; reset lands in its WAIT phase
    push(32'h60, 32'd80, 32'h400);
    push(32'h70, 32'd8, 32'h500);
    for (int n = 0; n < 20; n++) begin
      if (rle_start) break;
      step();
    end
    check("t6_started", rle_start, 1'b1);
    for (int n = 0; n < 20; n++) begin
      if (!rle_start) break;
      step();
    end
    check("t6_in_wait", rle_start, 1'b0);
    repeat (5) step();
    check("t6_addr", rle_message_addr, 32'h60);
    check("t6_pre_qcount", queue_count, 3'd1);
    reset = 1'b1;
    step();
    check("t6_rle_start", rle_start, 1'b0);
    check("t6_res_valid", res_valid, 1'b0);
    check("t6_qcount", queue_count, 3'd0);
    check("t6_total", total_cycles, 32'd0);
    check("t6_job_ready", job_ready, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_msg_addr", rle_message_addr, 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
